// File: rtl/mipi_pkg.sv
// Shared CSI-2 definitions for the MIPI receive path: data-type codes,
// counter saturation limits and the raw8_window state encoding.
package mipi_pkg;

  localparam logic [5:0] DT_RAW8  = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;

  localparam logic [9:0]  LINE_SAT = 10'd1023;
  localparam logic [15:0] COL_SAT  = 16'd65532;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_LINE  = 2'd2
  } raw8_window_state_t;

endpackage

// File: rtl/raw8_window_counter.sv
// Line/column position tracking for raw8_window. Both counters saturate
// rather than wrap, so an oversized frame can never alias back into the
// window. The window compares are combinational on the current position,
// i.e. the position of the beat being presented this cycle.
module raw8_window_counter
  import mipi_pkg::*;
#(
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int X_OFFSET = 0,
  parameter int Y_OFFSET = 0
) (
  input  logic        mipi_clk,
  input  logic        resetn,
  input  logic        i_clear,
  input  logic        i_beat,
  input  logic        i_close,
  output logic        o_in_window,
  output logic        o_first,
  output logic        o_last_line,
  output logic        o_line_full,
  output logic        o_lines_short,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic [9:0]  o_line_eff
);

  localparam logic [10:0] LP_Y_BEG = 11'(Y_OFFSET);
  localparam logic [10:0] LP_Y_END = 11'(Y_OFFSET + HEIGHT);
  localparam logic [16:0] LP_X_BEG = 17'(X_OFFSET);
  localparam logic [16:0] LP_X_END = 17'(X_OFFSET + WIDTH);

  logic [9:0]  r_line;
  logic [15:0] r_col;
  logic [10:0] w_line_ext;
  logic [16:0] w_col_ext;

  assign w_line_ext = {1'b0, r_line};
  assign w_col_ext  = {1'b0, r_col};

  // Advance position: frame restart clears, line close bumps the line, beats step the column.
  always_ff @(posedge mipi_clk or negedge resetn) begin
    if (!resetn) begin
      r_line <= '0;
      r_col  <= '0;
    end else if (i_clear) begin
      r_line <= '0;
      r_col  <= '0;
    end else if (i_close) begin
      if (r_line != LINE_SAT) r_line <= r_line + 10'd1;
      r_col <= '0;
    end else if (i_beat) begin
      if (r_col != COL_SAT) r_col <= r_col + 16'd4;
    end
  end

  assign o_in_window = (w_line_ext >= LP_Y_BEG) && (w_line_ext < LP_Y_END) &&
                       (w_col_ext >= LP_X_BEG) && (w_col_ext < LP_X_END);
  assign o_first     = (w_line_ext == LP_Y_BEG) && (w_col_ext == LP_X_BEG);
  assign o_last_line = (w_line_ext == LP_Y_END - 11'd1);
  // Column count at close is the line length; reaching the window's right edge means it was full.
  assign o_line_full = (w_col_ext >= LP_X_END);
  assign o_x         = 10'(r_col - 16'(X_OFFSET));
  assign o_y         = r_line - 10'(Y_OFFSET);
  // Line count including a line closing in this same cycle (matters when FE lands on the close).
  assign o_line_eff    = (i_close && (r_line != LINE_SAT)) ? r_line + 10'd1 : r_line;
  assign o_lines_short = ({1'b0, o_line_eff} < LP_Y_END);

endmodule

// File: rtl/raw8_window.sv
// RAW8 crop stage: keeps long packets of DATA_TYPE, forwards only beats
// inside the WIDTH x HEIGHT window at (X_OFFSET, Y_OFFSET), and flags
// per-frame length and short-frame errors. All outputs are registered.
// Optional RAW8_WINDOW_STATS_EN adds stat_lines / stat_last_word_count,
// captured at each frame end.
//
// state    | meaning
// ST_IDLE  | outside a frame, payload dropped
// ST_FRAME | inside a frame, between lines
// ST_LINE  | receiving payload of an accepted long packet
module raw8_window
  import mipi_pkg::*;
#(
  parameter int          WIDTH     = 640,
  parameter int          HEIGHT    = 480,
  parameter int          X_OFFSET  = 0,
  parameter int          Y_OFFSET  = 0,
  parameter logic [5:0]  DATA_TYPE = DT_RAW8
) (
  input  logic        mipi_clk,
  input  logic        resetn,
  input  logic [31:0] image_data,
  input  logic [5:0]  image_data_type,
  input  logic        image_data_enable,
  input  logic [15:0] word_count,
  input  logic        frame_start,
  input  logic        frame_end,
  output logic [31:0] window_data,
  output logic        window_enable,
  output logic [9:0]  window_x,
  output logic [9:0]  window_y,
  output logic        window_frame_start,
  output logic        window_frame_done,
  output logic        length_err,
`ifdef RAW8_WINDOW_STATS_EN
  output logic [9:0]  stat_lines,
  output logic [15:0] stat_last_word_count,
`endif
  output logic        short_frame_err
);

  raw8_window_state_t r_state, w_state_nxt;

  logic        w_type_ok, w_beat, w_close, w_enter, w_fe_act;
  logic        w_in_window, w_first, w_last_line, w_line_full, w_lines_short;
  logic [9:0]  w_x, w_y, w_line_eff;
  logic [15:0] r_bytes, r_wc;

  assign w_type_ok = image_data_enable && (image_data_type == DATA_TYPE);
  // A frame end only counts inside a frame and loses to a simultaneous frame start.
  assign w_fe_act  = frame_end && !frame_start && (r_state != ST_IDLE);

  raw8_window_counter #(
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .X_OFFSET (X_OFFSET),
    .Y_OFFSET (Y_OFFSET)
  ) u_counter (
    .mipi_clk      (mipi_clk),
    .resetn        (resetn),
    .i_clear       (frame_start),
    .i_beat        (w_beat),
    .i_close       (w_close),
    .o_in_window   (w_in_window),
    .o_first       (w_first),
    .o_last_line   (w_last_line),
    .o_line_full   (w_line_full),
    .o_lines_short (w_lines_short),
    .o_x           (w_x),
    .o_y           (w_y),
`ifdef RAW8_WINDOW_STATS_EN
    .o_line_eff    (w_line_eff)
`else
    .o_line_eff    (w_line_eff)
`endif
  );

  // State register.
  always_ff @(posedge mipi_clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state plus per-cycle beat/close/line-entry strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_beat      = 1'b0;
    w_close     = 1'b0;
    w_enter     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_start) w_state_nxt = ST_FRAME;
      end
      ST_FRAME: begin
        if (frame_start) begin
          w_state_nxt = ST_FRAME;
        end else begin
          if (w_type_ok) begin
            w_beat      = 1'b1;
            w_enter     = 1'b1;
            w_state_nxt = ST_LINE;
          end
          if (frame_end) w_state_nxt = ST_IDLE;
        end
      end
      ST_LINE: begin
        if (frame_start) begin
          w_state_nxt = ST_FRAME;
        end else begin
          if (image_data_enable) begin
            w_beat = w_type_ok;
          end else begin
            w_close     = 1'b1;
            w_state_nxt = ST_FRAME;
          end
          if (frame_end) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-line byte count and the word count latched on the packet's first beat.
  always_ff @(posedge mipi_clk or negedge resetn) begin
    if (!resetn) begin
      r_bytes <= '0;
      r_wc    <= '0;
    end else if (w_enter) begin
      r_bytes <= 16'd4;
      r_wc    <= word_count;
    end else if (w_beat) begin
      r_bytes <= r_bytes + 16'd4;
    end
  end

  // Sticky length error, cleared only by the next frame start.
  always_ff @(posedge mipi_clk or negedge resetn) begin
    if (!resetn)                           length_err <= 1'b0;
    else if (frame_start)                  length_err <= 1'b0;
    else if (w_close && (r_bytes != r_wc)) length_err <= 1'b1;
  end

  // Registered window outputs; data/position hold their last forwarded value.
  always_ff @(posedge mipi_clk or negedge resetn) begin
    if (!resetn) begin
      window_enable      <= 1'b0;
      window_data        <= '0;
      window_x           <= '0;
      window_y           <= '0;
      window_frame_start <= 1'b0;
      window_frame_done  <= 1'b0;
      short_frame_err    <= 1'b0;
    end else begin
      window_enable      <= w_beat && w_in_window;
      window_frame_start <= w_beat && w_in_window && w_first;
      window_frame_done  <= w_close && w_last_line && w_line_full;
      short_frame_err    <= w_fe_act && w_lines_short;
      if (w_beat && w_in_window) begin
        window_data <= image_data;
        window_x    <= w_x;
        window_y    <= w_y;
      end
    end
  end

`ifdef RAW8_WINDOW_STATS_EN
  // Frame statistics captured at each accepted frame end.
  always_ff @(posedge mipi_clk or negedge resetn) begin
    if (!resetn) begin
      stat_lines           <= '0;
      stat_last_word_count <= '0;
    end else if (w_fe_act) begin
      stat_lines           <= w_line_eff;
      stat_last_word_count <= r_wc;
    end
  end
`else
  logic w_unused_line_eff;
  assign w_unused_line_eff = ^w_line_eff;
`endif

endmodule
